// File: rtl/muldiv_arbiter.sv
// Round-robin arbiter sharing one iterative MulDiv unit between two requesters.
// Optional BUSY watchdog enabled by defining MULDIV_ARB_TIMEOUT_EN.
module muldiv_arbiter #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rq0_valid,
    output logic            rq0_ready,
    input  logic [3:0]      rq0_fn,
    input  logic            rq0_dw,
    input  logic [XLEN-1:0] rq0_in1,
    input  logic [XLEN-1:0] rq0_in2,
    input  logic            rq0_kill,
    input  logic            rq1_valid,
    output logic            rq1_ready,
    input  logic [3:0]      rq1_fn,
    input  logic            rq1_dw,
    input  logic [XLEN-1:0] rq1_in1,
    input  logic [XLEN-1:0] rq1_in2,
    input  logic            rq1_kill,
    output logic            rs0_valid,
    input  logic            rs0_ready,
    output logic [XLEN-1:0] rs0_data,
    output logic            rs1_valid,
    input  logic            rs1_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic            md_req_valid,
    input  logic            md_req_ready,
    output logic [3:0]      md_req_fn,
    output logic            md_req_dw,
    output logic [XLEN-1:0] md_req_in1,
    output logic [XLEN-1:0] md_req_in2,
    output logic            md_kill,
    input  logic            md_resp_valid,
    output logic            md_resp_ready,
    input  logic [XLEN-1:0] md_resp_data,
    output logic            timeout_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   rr_ptr_q, rr_ptr_d;

    logic   gnt_any, gnt_idx;
    logic   own_kill, own_rs_ready;
    logic   tmo_hit;
    logic   abort;

    if (TIMEOUT >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT");
    end

    assign gnt_any      = rq0_valid | rq1_valid;
    assign gnt_idx      = (rq0_valid & rq1_valid) ? rr_ptr_q : rq1_valid;
    assign own_kill     = owner_q ? rq1_kill : rq0_kill;
    assign own_rs_ready = owner_q ? rs1_ready : rs0_ready;
    assign abort        = (state_q == BUSY) & (own_kill | tmo_hit);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (gnt_any & md_req_ready) begin
                    state_d  = BUSY;
                    owner_d  = gnt_idx;
                    rr_ptr_d = ~gnt_idx;
                end
            end
            BUSY: begin
                if (abort || (md_resp_valid && own_rs_ready)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are gated by reset so nothing leaks while it is held.
    always_comb begin
        md_req_valid  = 1'b0;
        rq0_ready     = 1'b0;
        rq1_ready     = 1'b0;
        rs0_valid     = 1'b0;
        rs1_valid     = 1'b0;
        md_resp_ready = 1'b0;
        md_kill       = 1'b0;
        md_req_fn     = gnt_idx ? rq1_fn  : rq0_fn;
        md_req_dw     = gnt_idx ? rq1_dw  : rq0_dw;
        md_req_in1    = gnt_idx ? rq1_in1 : rq0_in1;
        md_req_in2    = gnt_idx ? rq1_in2 : rq0_in2;
        rs0_data      = md_resp_data;
        rs1_data      = md_resp_data;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    md_req_valid  = gnt_any;
                    rq0_ready     = gnt_any & ~gnt_idx & md_req_ready;
                    rq1_ready     = gnt_any &  gnt_idx & md_req_ready;
                    md_resp_ready = 1'b1;
                end
                BUSY: begin
                    md_kill       = abort;
                    rs0_valid     = ~owner_q & md_resp_valid & ~abort;
                    rs1_valid     =  owner_q & md_resp_valid & ~abort;
                    md_resp_ready = own_rs_ready;
                end
                default: ;
            endcase
        end
    end

`ifdef MULDIV_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q holds (BUSY cycle number - 1), so the kill lands on BUSY cycle TIMEOUT.
    assign tmo_hit     = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_err = err_q;

    always_comb begin
        cnt_d = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
        err_d = err_q | tmo_hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed bench for muldiv_arbiter: grant table plus multi-cycle sequences.
module tb_muldiv_arbiter;

    localparam int XLEN = 64;
`ifdef MULDIV_ARB_TIMEOUT_EN
    localparam int TMO = 8;
    localparam int CW  = 4;
`else
    localparam int TMO = 256;
    localparam int CW  = 9;
`endif
    localparam logic [XLEN-1:0] A0 = 64'h1111;
    localparam logic [XLEN-1:0] A1 = 64'h2222;

    logic            clock = 1'b0;
    logic            reset;
    logic            rq0_valid, rq0_ready, rq0_dw, rq0_kill;
    logic            rq1_valid, rq1_ready, rq1_dw, rq1_kill;
    logic [3:0]      rq0_fn, rq1_fn, md_req_fn;
    logic [XLEN-1:0] rq0_in1, rq0_in2, rq1_in1, rq1_in2;
    logic            rs0_valid, rs0_ready, rs1_valid, rs1_ready;
    logic [XLEN-1:0] rs0_data, rs1_data;
    logic            md_req_valid, md_req_ready, md_req_dw, md_kill;
    logic [XLEN-1:0] md_req_in1, md_req_in2, md_resp_data;
    logic            md_resp_valid, md_resp_ready, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    muldiv_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_fn(rq0_fn), .rq0_dw(rq0_dw),
        .rq0_in1(rq0_in1), .rq0_in2(rq0_in2), .rq0_kill(rq0_kill),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_fn(rq1_fn), .rq1_dw(rq1_dw),
        .rq1_in1(rq1_in1), .rq1_in2(rq1_in2), .rq1_kill(rq1_kill),
        .rs0_valid(rs0_valid), .rs0_ready(rs0_ready), .rs0_data(rs0_data),
        .rs1_valid(rs1_valid), .rs1_ready(rs1_ready), .rs1_data(rs1_data),
        .md_req_valid(md_req_valid), .md_req_ready(md_req_ready), .md_req_fn(md_req_fn),
        .md_req_dw(md_req_dw), .md_req_in1(md_req_in1), .md_req_in2(md_req_in2),
        .md_kill(md_kill), .md_resp_valid(md_resp_valid), .md_resp_ready(md_resp_ready),
        .md_resp_data(md_resp_data), .timeout_err(timeout_err)
    );

    typedef struct {
        logic            v0, v1, rdy, k0, k1;
        logic            exp_mv, exp_r0, exp_r1;
        logic [XLEN-1:0] exp_in1;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, A0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, A1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, A0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, A0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, A1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, A0};

        reset = 1'b0;
        rq0_valid = 0; rq0_dw = 0; rq0_kill = 0; rq0_fn = 4'd0; rq0_in1 = A0; rq0_in2 = 64'h5;
        rq1_valid = 0; rq1_dw = 1; rq1_kill = 0; rq1_fn = 4'd4; rq1_in1 = A1; rq1_in2 = 64'h7;
        rs0_ready = 0; rs1_ready = 0;
        md_req_ready = 0; md_resp_valid = 0; md_resp_data = '0;

        // Outputs held quiet while reset is asserted, even with live inputs.
        @(negedge clock);
        rq0_valid = 1; md_req_ready = 1; md_resp_valid = 1; rq0_kill = 1;
        #1;
        chk("rst_md_req_valid", md_req_valid, 0);
        chk("rst_rq0_ready", rq0_ready, 0);
        chk("rst_md_resp_ready", md_resp_ready, 0);
        chk("rst_md_kill", md_kill, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rq0_valid = 0; md_resp_valid = 0; rq0_kill = 0;
        @(negedge clock);
        reset = 1'b1;

        // IDLE grant table: inputs removed before the next edge so nothing is accepted.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            rq0_valid = tbl[i].v0; rq1_valid = tbl[i].v1; md_req_ready = tbl[i].rdy;
            rq0_kill = tbl[i].k0; rq1_kill = tbl[i].k1;
            #1;
            chk($sformatf("tbl%0d_md_req_valid", i), md_req_valid, tbl[i].exp_mv);
            chk($sformatf("tbl%0d_rq0_ready", i), rq0_ready, tbl[i].exp_r0);
            chk($sformatf("tbl%0d_rq1_ready", i), rq1_ready, tbl[i].exp_r1);
            chk($sformatf("tbl%0d_md_kill", i), md_kill, 0);
            chk($sformatf("tbl%0d_md_resp_ready", i), md_resp_ready, 1);
            if (tbl[i].exp_mv) chk($sformatf("tbl%0d_md_req_in1", i), md_req_in1, tbl[i].exp_in1);
            rq0_valid = 0; rq1_valid = 0; rq0_kill = 0; rq1_kill = 0;
        end

        // MUL 3*5 from rq0, with response backpressure for one cycle.
        @(negedge clock);
        rq0_valid = 1; rq0_fn = 4'd0; rq0_in1 = 3; rq0_in2 = 5; md_req_ready = 1;
        #1;
        chk("t1_md_req_valid", md_req_valid, 1);
        chk("t1_md_req_in1", md_req_in1, 3);
        chk("t1_md_req_in2", md_req_in2, 5);
        chk("t1_rq0_ready", rq0_ready, 1);
        step();
        rq0_valid = 0; rq1_valid = 1;
        #1;
        chk("t1_busy_rq1_ready", rq1_ready, 0);
        chk("t1_busy_md_req_valid", md_req_valid, 0);
        md_resp_valid = 1; md_resp_data = 15; rs0_ready = 0;
        #1;
        chk("t1_bp_rs0_valid", rs0_valid, 1);
        chk("t1_bp_md_resp_ready", md_resp_ready, 0);
        step();
        rs0_ready = 1;
        #1;
        chk("t1_rs0_valid", rs0_valid, 1);
        chk("t1_rs0_data", rs0_data, 15);
        chk("t1_rs1_valid", rs1_valid, 0);
        chk("t1_md_resp_ready", md_resp_ready, 1);
        step();
        md_resp_valid = 0;
        #1;
        chk("t1_idle_rq1_ready", rq1_ready, 1);
        rq1_valid = 0; rq0_in1 = A0; rq0_in2 = 64'h5; rs0_ready = 0;

        // Back-to-back contention after reset: grants alternate 0,1,0,1.
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        reset = 1;
        rq0_valid = 1; rq1_valid = 1; md_req_ready = 1;
        md_resp_valid = 1; md_resp_data = 64'h77; rs0_ready = 1; rs1_ready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_op%0d_rq0_ready", i), rq0_ready, (i % 2 == 0));
            chk($sformatf("t2_op%0d_rq1_ready", i), rq1_ready, (i % 2 == 1));
            chk($sformatf("t2_op%0d_md_req_in1", i), md_req_in1, (i % 2 == 1) ? A1 : A0);
            step();
            chk($sformatf("t2_op%0d_rs0_valid", i), rs0_valid, (i % 2 == 0));
            chk($sformatf("t2_op%0d_rs1_valid", i), rs1_valid, (i % 2 == 1));
            step();
        end
        rq0_valid = 0; rq1_valid = 0; md_resp_valid = 0; rs0_ready = 0; rs1_ready = 0;

        // Kill together with accept is ignored; owner kill beats a response.
        rq0_valid = 1; rq0_kill = 1;
        #1;
        chk("t3_accept_md_kill", md_kill, 0);
        chk("t3_accept_rq0_ready", rq0_ready, 1);
        step();
        rq0_valid = 0; rq0_kill = 0;
        #1;
        chk("t3_busy_md_resp_ready", md_resp_ready, 0);
        md_resp_valid = 1; rs0_ready = 1; rq0_kill = 1;
        #1;
        chk("t3_md_kill", md_kill, 1);
        chk("t3_rs0_valid", rs0_valid, 0);
        chk("t3_rs1_valid", rs1_valid, 0);
        step();
        rq0_kill = 0; md_resp_valid = 0; rs0_ready = 0;
        #1;
        chk("t3_idle_md_resp_ready", md_resp_ready, 1);
        chk("t3_idle_md_kill", md_kill, 0);

        // Non-owner kill is ignored; owner's response is delivered.
        rq0_valid = 1;
        step();
        rq0_valid = 0; rq1_kill = 1; md_resp_valid = 1; md_resp_data = 42; rs0_ready = 1;
        #1;
        chk("t4_md_kill", md_kill, 0);
        chk("t4_rs0_valid", rs0_valid, 1);
        chk("t4_rs0_data", rs0_data, 42);
        step();
        rq1_kill = 0; md_resp_valid = 0; rs0_ready = 0;
        #1;
        chk("t4_idle_md_resp_ready", md_resp_ready, 1);

        // Reset mid-op (rr_ptr points at rq1 beforehand), then first grant is rq0.
        rq0_valid = 1;
        step();
        rq0_valid = 0; rq1_valid = 1; md_resp_valid = 1; rs0_ready = 1; rq0_kill = 1;
        reset = 0;
        #1;
        chk("t5_rq0_ready", rq0_ready, 0);
        chk("t5_rq1_ready", rq1_ready, 0);
        chk("t5_rs0_valid", rs0_valid, 0);
        chk("t5_rs1_valid", rs1_valid, 0);
        chk("t5_md_req_valid", md_req_valid, 0);
        chk("t5_md_resp_ready", md_resp_ready, 0);
        chk("t5_md_kill", md_kill, 0);
        rq0_kill = 0; md_resp_valid = 0; rs0_ready = 0; rq1_valid = 0;
        @(negedge clock);
        reset = 1; rq0_valid = 1; rq1_valid = 1;
        #1;
        chk("t5_post_rq0_ready", rq0_ready, 1);
        chk("t5_post_rq1_ready", rq1_ready, 0);
        chk("t5_post_md_req_in1", md_req_in1, A0);
        rq0_valid = 0; rq1_valid = 0;

`ifdef MULDIV_ARB_TIMEOUT_EN
        // Watchdog: kill pulse on BUSY cycle 8, sticky error until reset.
        @(negedge clock);
        rq0_valid = 1;
        step();
        rq0_valid = 0;
        #1;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("t6_cyc%0d_md_kill", k), md_kill, (k == 8));
            chk($sformatf("t6_cyc%0d_timeout_err", k), timeout_err, 0);
            step();
        end
        chk("t6_idle_md_kill", md_kill, 0);
        chk("t6_idle_md_resp_ready", md_resp_ready, 1);
        chk("t6_timeout_err_set", timeout_err, 1);
        repeat (3) step();
        chk("t6_timeout_err_sticky", timeout_err, 1);
        @(negedge clock);
        reset = 0;
        #1;
        chk("t6_timeout_err_reset", timeout_err, 0);
        @(negedge clock);
        reset = 1;
`else
        // Without the watchdog, BUSY is unbounded and timeout_err stays 0.
        @(negedge clock);
        rq0_valid = 1;
        step();
        rq0_valid = 0;
        repeat (20) step();
        chk("t6_long_md_kill", md_kill, 0);
        chk("t6_long_md_resp_ready", md_resp_ready, 0);
        chk("t6_long_timeout_err", timeout_err, 0);
        md_resp_valid = 1; rs0_ready = 1;
        #1;
        chk("t6_long_rs0_valid", rs0_valid, 1);
        step();
        md_resp_valid = 0; rs0_ready = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
